demux1_4_tdm: RTL and testbench

- Registered 1-to-4 time-division demultiplexer: the inverse of the team's 4:1 select mux.
- Accepts one sample stream and distributes consecutive samples to four output lanes.
- Lane selection comes from an internal frame-slot counter (auto mode) or from an explicit select input (direct mode).
- Sits on the receive side of a link whose transmit side merges four lanes through the 4:1 mux.

---
 rtl/demux1_4_tdm.sv | 173 +++++++++++++++++
 tb/tb_demux1_4_tdm.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1_4_tdm.sv
// -----------------------------------------------------------------------------
// demux1_4_tdm
//
// Registered 1-to-4 time-division demultiplexer. Consecutive samples of one
// input stream are distributed over four output lanes, either by an internal
// frame-slot counter (auto mode, frames delimited by sof) or by an explicit
// lane select (direct mode). Receive-side counterpart of the 4:1 select mux.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   din         incoming sample (WIDTH bits)
//   din_valid   din carries a sample this cycle
//   sof         start of frame, qualified by din_valid; marks the slot-0 sample
//   sel_mode    0 = auto (slot counter), 1 = direct (sel_in)
//   sel_in      lane select used in direct mode
//   dout        four lanes, lane k at [k*WIDTH +: WIDTH]; unwritten lanes hold
//   dout_valid  per-lane one-cycle pulse, lane k was updated (one-hot or zero)
//   frame_done  one-cycle pulse, slot 3 of a frame was written
//   frame_err   one-cycle pulse, sof arrived mid-frame
//   dframe      (only with DEMUX_FRAME_LATCH_EN) last complete auto-mode frame
//
// Optional feature macro: DEMUX_FRAME_LATCH_EN
//   Adds a shadow register collecting auto-mode samples and the dframe output,
//   which loads all four lanes atomically on the edge that raises frame_done.
// -----------------------------------------------------------------------------
module demux1_4_tdm #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   din,
    input  logic               din_valid,
    input  logic               sof,
    input  logic               sel_mode,
    input  logic [1:0]         sel_in,
    output logic [4*WIDTH-1:0] dout,
    output logic [3:0]         dout_valid,
    output logic               frame_done,
    output logic               frame_err
`ifdef DEMUX_FRAME_LATCH_EN
    ,
    output logic [4*WIDTH-1:0] dframe
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d, cur_state;
    logic [1:0]         slot_q, slot_d, cur_slot;
    logic               mode_q, mode_d;
    logic [4*WIDTH-1:0] dout_q, dout_d;
    logic [3:0]         dout_valid_q, dout_valid_d;
    logic               frame_done_q, frame_done_d;
    logic               frame_err_q, frame_err_d;
    logic               mode_change;
    logic               wr_en;
    logic [1:0]         wr_lane;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        mode_change  = (sel_mode != mode_q);
        // A mode switch abandons any frame in progress; the sample of this
        // cycle is then handled as if the FSM were already idle.
        cur_state    = mode_change ? IDLE : state_q;
        cur_slot     = mode_change ? 2'd0 : slot_q;

        state_d      = cur_state;
        slot_d       = cur_slot;
        mode_d       = sel_mode;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        wr_en        = 1'b0;
        wr_lane      = 2'd0;

        if (din_valid) begin
            if (sel_mode) begin
                wr_en   = 1'b1;
                wr_lane = sel_in;
            end else if (sof) begin
                // sof always restarts at slot 0; when a frame was already
                // open (including one about to write slot 3) it is an error.
                wr_en       = 1'b1;
                wr_lane     = 2'd0;
                frame_err_d = (cur_state == RUN);
                state_d     = RUN;
                slot_d      = 2'd1;
            end else if (cur_state == RUN) begin
                wr_en   = 1'b1;
                wr_lane = cur_slot;
                if (cur_slot == 2'd3) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                    slot_d       = 2'd0;
                end else begin
                    slot_d = cur_slot + 2'd1;
                end
            end
            // Non-sof samples while IDLE in auto mode are dropped.
        end

        dout_d       = dout_q;
        dout_valid_d = 4'b0000;
        if (wr_en) begin
            dout_d[int'(wr_lane)*WIDTH +: WIDTH] = din;
            dout_valid_d[wr_lane]                = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            slot_q       <= 2'd0;
            mode_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 4'b0000;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q      <= state_d;
            slot_q       <= slot_d;
            mode_q       <= mode_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

`ifdef DEMUX_FRAME_LATCH_EN
    logic [4*WIDTH-1:0] shadow_q, shadow_d;
    logic [4*WIDTH-1:0] dframe_q, dframe_d;

    always_comb begin
        shadow_d = shadow_q;
        dframe_d = dframe_q;
        if (wr_en && !sel_mode) begin
            shadow_d[int'(wr_lane)*WIDTH +: WIDTH] = din;
        end
        // shadow_d already contains the slot-3 sample, so the whole frame
        // is published on the same edge that raises frame_done.
        if (frame_done_d) begin
            dframe_d = shadow_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shadow storage is reset as well; it is small, and a
            // known value keeps dframe free of X after any reset sequence.
            shadow_q <= '0;
            dframe_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            dframe_q <= dframe_d;
        end
    end

    assign dframe = dframe_q;
`endif

endmodule

// File: tb/tb_demux1_4_tdm.sv
// -----------------------------------------------------------------------------
// tb_demux1_4_tdm
//
// Directed scenarios followed by randomized traffic; every cycle's outputs
// are compared with a behavioural frame model kept in this bench.
// -----------------------------------------------------------------------------
module tb_demux1_4_tdm;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [W-1:0]   din;
    logic           din_valid;
    logic           sof;
    logic           sel_mode;
    logic [1:0]     sel_in;
    logic [4*W-1:0] dout;
    logic [3:0]     dout_valid;
    logic           frame_done;
    logic           frame_err;
`ifdef DEMUX_FRAME_LATCH_EN
    logic [4*W-1:0] dframe;
`endif

    int errors = 0;
    int checks = 0;

    demux1_4_tdm #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .sof        (sof),
        .sel_mode   (sel_mode),
        .sel_in     (sel_in),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_done (frame_done),
        .frame_err  (frame_err)
`ifdef DEMUX_FRAME_LATCH_EN
        ,
        .dframe     (dframe)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_lane [4];
    logic [W-1:0] m_shadow [4];
    logic [W-1:0] m_frame [4];
    logic [3:0]   m_valid;
    logic         m_done;
    logic         m_err;
    int           m_next;       // next slot expected, -1 = waiting for sof
    logic         m_prev_mode;

    function automatic logic [4*W-1:0] pack(input logic [W-1:0] l [4]);
        return {l[3], l[2], l[1], l[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_lane[i]   = '0;
            m_shadow[i] = '0;
            m_frame[i]  = '0;
        end
        m_valid     = '0;
        m_done      = 1'b0;
        m_err       = 1'b0;
        m_next      = -1;
        m_prev_mode = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic s, input logic m,
                              input logic [1:0] sel, input logic [W-1:0] d);
        m_valid = '0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        if (m != m_prev_mode) m_next = -1;
        m_prev_mode = m;
        if (v) begin
            if (m) begin
                m_lane[sel]  = d;
                m_valid[sel] = 1'b1;
            end else if (s) begin
                if (m_next != -1) m_err = 1'b1;
                m_lane[0]   = d;
                m_shadow[0] = d;
                m_valid[0]  = 1'b1;
                m_next      = 1;
            end else if (m_next != -1) begin
                m_lane[m_next]   = d;
                m_shadow[m_next] = d;
                m_valid[m_next]  = 1'b1;
                if (m_next == 3) begin
                    m_done = 1'b1;
                    for (int i = 0; i < 4; i++) m_frame[i] = m_shadow[i];
                    m_next = -1;
                end else begin
                    m_next++;
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".dout"},       dout,       pack(m_lane));
        check({tag, ".dout_valid"}, dout_valid, m_valid);
        check({tag, ".frame_done"}, frame_done, m_done);
        check({tag, ".frame_err"},  frame_err,  m_err);
`ifdef DEMUX_FRAME_LATCH_EN
        check({tag, ".dframe"},     dframe,     pack(m_frame));
`endif
    endtask

    // Drive one cycle of inputs, clock it, then compare #1 after the edge.
    task automatic step(input string tag, input logic v, input logic s,
                        input logic m, input logic [1:0] sel,
                        input logic [W-1:0] d);
        din_valid = v;
        sof       = s;
        sel_mode  = m;
        sel_in    = sel;
        din       = d;
        @(posedge clk);
        model_step(v, s, m, sel, d);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 2'd0, '0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".dout"},       dout,       '0);
        check({tag, ".dout_valid"}, dout_valid, '0);
        check({tag, ".frame_done"}, frame_done, '0);
        check({tag, ".frame_err"},  frame_err,  '0);
`ifdef DEMUX_FRAME_LATCH_EN
        check({tag, ".dframe"},     dframe,     '0);
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        sof       = 1'b0;
        sel_mode  = 1'b0;
        sel_in    = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full auto frame on consecutive cycles.
        step("f1s0", 1'b1, 1'b1, 1'b0, 2'd0, 8'h11);
        step("f1s1", 1'b1, 1'b0, 1'b0, 2'd0, 8'h22);
        step("f1s2", 1'b1, 1'b0, 1'b0, 2'd0, 8'h33);
        step("f1s3", 1'b1, 1'b0, 1'b0, 2'd0, 8'h44);
        check("f1.dout_const",  dout,       32'h44332211);
        check("f1.valid_const", dout_valid, 4'h8);
        check("f1.done_const",  frame_done, 1'b1);
        idle("f1gap", 1);

        // Gapped frame, then a sample without sof.
        step("f2s0", 1'b1, 1'b1, 1'b0, 2'd0, 8'h11);
        step("f2s1", 1'b1, 1'b0, 1'b0, 2'd0, 8'h22);
        idle("f2gap", 3);
        step("f2s2", 1'b1, 1'b0, 1'b0, 2'd0, 8'h33);
        step("f2s3", 1'b1, 1'b0, 1'b0, 2'd0, 8'h44);
        check("f2.dout_const", dout,       32'h44332211);
        check("f2.done_const", frame_done, 1'b1);
        step("nosof", 1'b1, 1'b0, 1'b0, 2'd0, 8'h55);
        check("nosof.valid_const", dout_valid, 4'h0);
        check("nosof.dout_const",  dout,       32'h44332211);

        // Mid-frame sof.
        step("mf0", 1'b1, 1'b1, 1'b0, 2'd0, 8'hA0);
        step("mf1", 1'b1, 1'b0, 1'b0, 2'd0, 8'hA1);
        step("mf2", 1'b1, 1'b1, 1'b0, 2'd0, 8'hB0);
        check("mf.err_const",   frame_err,  1'b1);
        check("mf.valid_const", dout_valid, 4'h1);
        check("mf.lane0_const", dout[7:0],  8'hB0);
        check("mf.lane1_const", dout[15:8], 8'hA1);
        step("mf3", 1'b1, 1'b0, 1'b0, 2'd0, 8'hB1);
        step("mf4", 1'b1, 1'b0, 1'b0, 2'd0, 8'hB2);
        step("mf5", 1'b1, 1'b0, 1'b0, 2'd0, 8'hB3);
        check("mf.dout_const", dout,       32'hB3B2B1B0);
        check("mf.done_const", frame_done, 1'b1);

        // sof colliding with the slot-3 write counts as mid-frame sof.
        step("col0", 1'b1, 1'b1, 1'b0, 2'd0, 8'hC0);
        step("col1", 1'b1, 1'b0, 1'b0, 2'd0, 8'hC1);
        step("col2", 1'b1, 1'b0, 1'b0, 2'd0, 8'hC2);
        step("col3", 1'b1, 1'b1, 1'b0, 2'd0, 8'hC3);
        check("col.err_const",  frame_err,  1'b1);
        check("col.done_const", frame_done, 1'b0);

        // Direct mode (also abandons the open frame without frame_err).
        step("dir0", 1'b1, 1'b0, 1'b1, 2'd2, 8'h7E);
        check("dir0.valid_const", dout_valid,   4'h4);
        check("dir0.lane2_const", dout[23:16],  8'h7E);
        step("dir1", 1'b1, 1'b1, 1'b1, 2'd0, 8'h01);
        check("dir1.valid_const", dout_valid, 4'h1);
        check("dir1.lane0_const", dout[7:0],  8'h01);
        check("dir1.err_const",   frame_err,  1'b0);
        check("dir1.done_const",  frame_done, 1'b0);
        // Back to auto: a non-sof sample right after the switch is dropped.
        step("back", 1'b1, 1'b0, 1'b0, 2'd1, 8'h5A);
        check("back.valid_const", dout_valid, 4'h0);

        // Asynchronous reset between edges after slot 1.
        step("ar0", 1'b1, 1'b1, 1'b0, 2'd0, 8'hD0);
        step("ar1", 1'b1, 1'b0, 1'b0, 2'd0, 8'hD1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("ar99", 1'b1, 1'b0, 1'b0, 2'd0, 8'h99);
        check("ar99.valid_const", dout_valid, 4'h0);
        check("ar99.dout_const",  dout,       32'h0);

`ifdef DEMUX_FRAME_LATCH_EN
        // Aborted frame followed by a full frame.
        step("fl0", 1'b1, 1'b1, 1'b0, 2'd0, 8'hE0);
        step("fl1", 1'b1, 1'b0, 1'b0, 2'd0, 8'hE1);
        step("fl2", 1'b1, 1'b1, 1'b0, 2'd0, 8'h01);
        step("fl3", 1'b1, 1'b0, 1'b0, 2'd0, 8'h02);
        step("fl4", 1'b1, 1'b0, 1'b0, 2'd0, 8'h03);
        check("fl.before_const", dframe, 32'h0);
        step("fl5", 1'b1, 1'b0, 1'b0, 2'd0, 8'h04);
        check("fl.after_const", dframe, 32'h04030201);
        // Direct mode must not touch dframe.
        step("fl6", 1'b1, 1'b0, 1'b1, 2'd3, 8'hFF);
        check("fl.direct_const", dframe, 32'h04030201);
`endif

        // Randomized traffic against the model.
        begin
            logic rm;
            rm = 1'b0;
            for (int i = 0; i < 400; i++) begin
                logic          rv, rs;
                logic [1:0]    rsel;
                logic [W-1:0]  rd;
                if ($urandom_range(0, 19) == 0) rm = ~rm;
                rv   = ($urandom_range(0, 3) != 0);
                rs   = ($urandom_range(0, 4) == 0);
                rsel = 2'($urandom_range(0, 3));
                rd   = W'($urandom);
                step("rand", rv, rs, rm, rsel, rd);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
